div: RTL and testbench

DIV -- requirements
Module: div

---
 rtl/div.sv | 113 +++++++++++
 tb/tb_div.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/div.sv
// Multi-cycle restoring divider (signed/unsigned), result {remainder, quotient}; ready 34 edges after accept incl. accept edge for DIV_W=32, 2 for divisor 0.
// No backpressure: start_i is held until ready_o, result then holds until start_i drops.
module div #(
   parameter int DIV_W = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               signed_div_i,
   input  logic [DIV_W-1:0]   opdata1_i,
   input  logic [DIV_W-1:0]   opdata2_i,
   input  logic               start_i,
   input  logic               annul_i,
   output logic [2*DIV_W-1:0] result_o,
   output logic               ready_o
);

   localparam int CW = $clog2(DIV_W + 1);
   localparam logic [CW-1:0] LAST = CW'(DIV_W);

   typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [DIV_W-1:0] quo;
   logic [DIV_W-1:0] rem;
   logic [DIV_W-1:0] dvs;
   logic             neg_q;
   logic             neg_r;

   logic [DIV_W-1:0] a_abs;
   logic [DIV_W-1:0] b_abs;
   logic [DIV_W:0]   partial;
   logic [DIV_W:0]   diff;

   always_comb begin
      a_abs   = (signed_div_i && opdata1_i[DIV_W-1]) ? -opdata1_i : opdata1_i;
      b_abs   = (signed_div_i && opdata2_i[DIV_W-1]) ? -opdata2_i : opdata2_i;
      partial = {rem, quo[DIV_W-1]};
      // MSB of diff is the borrow: set when the shifted remainder is below the divisor
      diff    = partial - {1'b0, dvs};
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= FREE;
         cnt      <= '0;
         quo      <= '0;
         rem      <= '0;
         dvs      <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         result_o <= '0;
         ready_o  <= 1'b0;
      end else begin
         case (state)
            FREE: begin
               ready_o  <= 1'b0;
               result_o <= '0;
               if (start_i && !annul_i) begin
                  if (opdata2_i == '0) begin
                     state <= BYZERO;
                  end else begin
                     state <= ON;
                     cnt   <= '0;
                     quo   <= a_abs;
                     rem   <= '0;
                     dvs   <= b_abs;
                     neg_q <= signed_div_i & (opdata1_i[DIV_W-1] ^ opdata2_i[DIV_W-1]);
                     neg_r <= signed_div_i & opdata1_i[DIV_W-1];
                  end
               end
            end
            BYZERO: begin
               if (annul_i) begin
                  state <= FREE;
               end else begin
                  state    <= END;
                  result_o <= '0;
                  ready_o  <= 1'b1;
               end
            end
            ON: begin
               if (annul_i) begin
                  state    <= FREE;
                  result_o <= '0;
                  ready_o  <= 1'b0;
               end else if (cnt == LAST) begin
                  state    <= END;
                  result_o <= {(neg_r ? -rem : rem), (neg_q ? -quo : quo)};
                  ready_o  <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
                  if (!diff[DIV_W]) begin
                     rem <= diff[DIV_W-1:0];
                     quo <= {quo[DIV_W-2:0], 1'b1};
                  end else begin
                     rem <= partial[DIV_W-1:0];
                     quo <= {quo[DIV_W-2:0], 1'b0};
                  end
               end
            end
            END: begin
               if (!start_i) begin
                  state    <= FREE;
                  result_o <= '0;
                  ready_o  <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div.sv
// Scoreboard bench for div: driver pushes expected {rem,quo} and latency, monitor pops on each ready rise.
// Latency is counted in edges including the acceptance edge.
module tb_div;
   localparam int W = 32;

   logic           clk = 1'b0;
   logic           rst;
   logic           signed_div;
   logic [W-1:0]   op1;
   logic [W-1:0]   op2;
   logic           start;
   logic           annul;
   logic [2*W-1:0] result;
   logic           ready;

   div #(.DIV_W(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div),
      .opdata1_i    (op1),
      .opdata2_i    (op2),
      .start_i      (start),
      .annul_i      (annul),
      .result_o     (result),
      .ready_o      (ready)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [63:0] res;
      int          lat;
      int          acc;
   } exp_t;

   exp_t exp_q[$];
   int   pass_cnt = 0;
   int   chk_cnt  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      chk_cnt++;
      if (act === req) pass_cnt++;
      else $display("FAIL %s: got %h, required %h", name, act, req);
   endtask

   // Reference: plain arithmetic on 64-bit integers, so -2^31/-1 needs no special case
   function automatic logic [63:0] model(input bit s, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb, q, r;
      logic [63:0] qv, rv;
      logic [31:0] uq, ur;
      if (b == 0) return 64'd0;
      if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q  = sa / sb;
         r  = sa % sb;
         qv = q;
         rv = r;
         return {rv[31:0], qv[31:0]};
      end
      uq = a / b;
      ur = a % b;
      return {ur, uq};
   endfunction

   // Called at a negedge; the following posedge is the acceptance edge
   task automatic issue(input bit s, input logic [31:0] a, input logic [31:0] b, input logic [63:0] res);
      signed_div = s;
      op1        = a;
      op2        = b;
      start      = 1'b1;
      exp_q.push_back('{res: res, lat: (b == 0) ? 2 : W + 2, acc: cyc + 1});
      @(negedge clk);
      op1        = $urandom;
      op2        = $urandom;
      signed_div = 1'($urandom % 2);
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!ready) begin
         chk_cnt++;
         $display("FAIL ready_timeout: ready=%0b after %0d cycles, required 1", ready, n);
      end
   endtask

   task automatic finish_op(input int hold, input bit poke_annul);
      wait_ready();
      annul = poke_annul;
      repeat (hold) @(negedge clk);
      annul = 1'b0;
      start = 1'b0;
      @(negedge clk);
      check("exit_ready", 64'(ready), 64'd0);
      check("exit_result", result, 64'd0);
   endtask

   // Monitor
   initial begin
      exp_t cur;
      bit   prev = 1'b0;
      cur = '{res: 64'd0, lat: 0, acc: 0};
      forever begin
         @(negedge clk);
         if (ready && !prev) begin
            if (exp_q.size() == 0) begin
               chk_cnt++;
               $display("FAIL unexpected_ready: ready=1 result=%h, required no ready", result);
            end else begin
               cur = exp_q.pop_front();
               check("result", result, cur.res);
               check("latency", 64'(cyc - cur.acc + 1), 64'(cur.lat));
            end
         end else if (ready && prev) begin
            check("hold_result", result, cur.res);
         end
         prev = ready;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, required completion");
      $fatal(1);
   end

   initial begin
      bit          s;
      logic [31:0] a, b;
      rst = 1'b0; start = 1'b0; annul = 1'b0; signed_div = 1'b0; op1 = '0; op2 = '0;
      repeat (3) @(negedge clk);
      check("reset_ready", 64'(ready), 64'd0);
      check("reset_result", result, 64'd0);
      rst = 1'b1;
      @(negedge clk);

      issue(0, 32'd100, 32'd7, 64'h00000002_0000000E);       finish_op(0, 0);
      issue(1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD);  finish_op(1, 0);
      issue(0, 32'hFFFFFFF9, 32'd2, 64'h00000001_7FFFFFFC);  finish_op(0, 0);
      issue(0, 32'h12345678, 32'd0, 64'd0);                  finish_op(0, 0);

      // Abort during the 10th ON cycle
      signed_div = 1'b0; op1 = 32'hFFFFFFFF; op2 = 32'd3; start = 1'b1;
      repeat (10) @(negedge clk);
      annul = 1'b1;
      @(negedge clk);
      check("annul_ready", 64'(ready), 64'd0);
      check("annul_result", result, 64'd0);
      annul = 1'b0;
      issue(0, 32'd9, 32'd3, 64'h00000000_00000003);         finish_op(0, 0);

      // Hold in END with annul asserted, which must be ignored
      issue(0, 32'd1000, 32'd9, model(0, 32'd1000, 32'd9));  finish_op(3, 1);

      // Reset in the 20th ON cycle
      signed_div = 1'b0; op1 = 32'hDEADBEEF; op2 = 32'd5; start = 1'b1;
      repeat (20) @(negedge clk);
      rst = 1'b0; start = 1'b0;
      @(negedge clk);
      check("rst_on_ready", 64'(ready), 64'd0);
      check("rst_on_result", result, 64'd0);
      rst = 1'b1;
      @(negedge clk);
      issue(1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000); finish_op(0, 0);

      // Reset while in END
      issue(1, 32'hFFFFFF00, 32'd7, model(1, 32'hFFFFFF00, 32'd7));
      wait_ready();
      rst = 1'b0;
      @(negedge clk);
      check("rst_end_ready", 64'(ready), 64'd0);
      check("rst_end_result", result, 64'd0);
      rst = 1'b1; start = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 40; i++) begin
         s = 1'($urandom % 2);
         a = $urandom;
         case ($urandom % 5)
            0:       b = 32'd0;
            1:       b = $urandom_range(1, 15);
            2:       begin b = 32'hFFFFFFFF; a = 32'h80000000; end
            3:       b = 32'h80000000 | $urandom;
            default: b = $urandom;
         endcase
         issue(s, a, b, model(s, a, b));
         finish_op(int'($urandom % 4), 1'($urandom % 2));
      end

      @(negedge clk);
      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
